// File: rtl/uni_register_pkg.sv
// Shared definitions for the multi-mode register: the operation encodings and
// a name lookup for messages.
package uni_register_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'd0,
        MODE_LOAD = 3'd1,
        MODE_INC  = 3'd2,
        MODE_DEC  = 3'd3,
        MODE_SHL  = 3'd4,
        MODE_SHR  = 3'd5,
        MODE_ROL  = 3'd6,
        MODE_ROR  = 3'd7
    } mode_e;

    function automatic string mode_name(input mode_e m);
        case (m)
            MODE_HOLD: return "HOLD";
            MODE_LOAD: return "LOAD";
            MODE_INC:  return "INC";
            MODE_DEC:  return "DEC";
            MODE_SHL:  return "SHL";
            MODE_SHR:  return "SHR";
            MODE_ROL:  return "ROL";
            MODE_ROR:  return "ROR";
            default:   return "???";
        endcase
    endfunction

endpackage

// File: rtl/uni_register_if.sv
// Control/data bundle of the multi-mode register; the master drives the
// operation, the slave (the register) returns its contents and status.
interface uni_register_if #(
    parameter int unsigned WIDTH = 8
);
    import uni_register_pkg::*;

    logic             en;
    mode_e            mode;
    logic [WIDTH-1:0] data;
    logic             sin;
    logic [WIDTH-1:0] out;
    logic             cout;
    logic             zero;

    modport master (
        output en, mode, data, sin,
        input  out, cout, zero
    );

    modport slave (
        input  en, mode, data, sin,
        output out, cout, zero
    );

endinterface

// File: rtl/uni_register_next.sv
// Combinational next-state of the register for the selected operation,
// ignoring enable and reset.
module uni_register_next
    import uni_register_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] out,
    input  logic             cout,
    input  logic [WIDTH-1:0] data,
    input  logic             sin,
    input  mode_e            mode,
    output logic [WIDTH-1:0] next_out,
    output logic             next_cout
);

    always_comb begin
        next_out  = out;
        next_cout = cout;
        case (mode)
            MODE_HOLD: begin
                next_out  = out;
                next_cout = cout;
            end
            MODE_LOAD: begin
                next_out  = data;
                next_cout = 1'b0;
            end
            MODE_INC: begin
                next_out  = out + WIDTH'(1);
                next_cout = &out;
            end
            MODE_DEC: begin
                next_out  = out - WIDTH'(1);
                next_cout = (out == '0);
            end
            MODE_SHL: begin
                next_out  = {out[WIDTH-2:0], sin};
                next_cout = out[WIDTH-1];
            end
            MODE_SHR: begin
                next_out  = {sin, out[WIDTH-1:1]};
                next_cout = out[0];
            end
            MODE_ROL: begin
                next_out  = {out[WIDTH-2:0], out[WIDTH-1]};
                next_cout = out[WIDTH-1];
            end
            MODE_ROR: begin
                next_out  = {out[0], out[WIDTH-1:1]};
                next_cout = out[0];
            end
            default: begin
                next_out  = out;
                next_cout = cout;
            end
        endcase
    end

endmodule

// File: rtl/uni_register.sv
// Parametrised multi-mode register (load/count/shift/rotate) with registered
// carry-out and combinational zero flag.
module uni_register
    import uni_register_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter logic [31:0] RESET_VAL = 32'd0
) (
    input logic              clk,
    input logic              rst,
    uni_register_if.slave    bus
);

    localparam logic [WIDTH-1:0] RST_VAL = RESET_VAL[WIDTH-1:0];

    logic [WIDTH-1:0] out_q, out_d, next_out;
    logic             cout_q, cout_d, next_cout;

    uni_register_next #(
        .WIDTH(WIDTH)
    ) u_next (
        .out       (out_q),
        .cout      (cout_q),
        .data      (bus.data),
        .sin       (bus.sin),
        .mode      (bus.mode),
        .next_out  (next_out),
        .next_cout (next_cout)
    );

    always_comb begin
        out_d  = out_q;
        cout_d = cout_q;
        if (bus.en) begin
            out_d  = next_out;
            cout_d = next_cout;
        end
    end

    // Reset is tested first so en/mode are don't-care while rst is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q  <= RST_VAL;
            cout_q <= 1'b0;
        end else begin
            out_q  <= out_d;
            cout_q <= cout_d;
        end
    end

    assign bus.out  = out_q;
    assign bus.cout = cout_q;
    assign bus.zero = (out_q == '0);

endmodule

// File: tb/tb_uni_register.sv
// Directed bench for uni_register: a table of 8-bit vectors plus hand-written
// reset-priority and 16-bit sequences.
module tb_uni_register;
    import uni_register_pkg::*;

    logic clk = 1'b0;
    logic rst8, rst16;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    uni_register_if #(.WIDTH(8))  bus8  ();
    uni_register_if #(.WIDTH(16)) bus16 ();

    uni_register #(.WIDTH(8), .RESET_VAL(32'h0)) dut8 (
        .clk (clk),
        .rst (rst8),
        .bus (bus8)
    );

    uni_register #(.WIDTH(16), .RESET_VAL(32'h00FF)) dut16 (
        .clk (clk),
        .rst (rst16),
        .bus (bus16)
    );

    typedef struct {
        logic       rst;
        logic       en;
        logic [2:0] mode;
        logic [7:0] data;
        logic       sin;
        logic [7:0] exp_out;
        logic       exp_cout;
        logic       exp_zero;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic e, input logic [2:0] m,
                                input logic [7:0] d, input logic s,
                                input logic [7:0] eo, input logic ec, input logic ez);
        vec_t v;
        v.rst = r; v.en = e; v.mode = m; v.data = d; v.sin = s;
        v.exp_out = eo; v.exp_cout = ec; v.exp_zero = ez;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic drive8(input logic r, input logic e, input logic [2:0] m,
                          input logic [7:0] d, input logic s);
        rst8       = r;
        bus8.en    = e;
        bus8.mode  = mode_e'(m);
        bus8.data  = d;
        bus8.sin   = s;
        @(posedge clk);
        #1;
    endtask

    task automatic check8(input string tag, input logic [7:0] eo, input logic ec, input logic ez);
        chk({tag, " out"},  32'(bus8.out),  32'(eo));
        chk({tag, " cout"}, 32'(bus8.cout), 32'(ec));
        chk({tag, " zero"}, 32'(bus8.zero), 32'(ez));
    endtask

    task automatic drive16(input logic r, input logic e, input logic [2:0] m,
                           input logic [15:0] d, input logic s);
        rst16       = r;
        bus16.en    = e;
        bus16.mode  = mode_e'(m);
        bus16.data  = d;
        bus16.sin   = s;
        @(posedge clk);
        #1;
    endtask

    task automatic check16(input string tag, input logic [15:0] eo, input logic ec, input logic ez);
        chk({tag, " out"},  32'(bus16.out),  32'(eo));
        chk({tag, " cout"}, 32'(bus16.cout), 32'(ec));
        chk({tag, " zero"}, 32'(bus16.zero), 32'(ez));
    endtask

    initial begin
        rst8 = 1'b1; bus8.en = 1'b0; bus8.mode = MODE_HOLD; bus8.data = '0; bus8.sin = 1'b0;
        rst16 = 1'b1; bus16.en = 1'b0; bus16.mode = MODE_HOLD; bus16.data = '0; bus16.sin = 1'b0;

        //          rst  en   mode data   sin  out    cout zero
        vecs.push_back(mk(1, 1, 2, 8'h55, 1, 8'h00, 0, 1));  // reset wins over INC
        vecs.push_back(mk(0, 1, 1, 8'hA5, 0, 8'hA5, 0, 0));
        vecs.push_back(mk(0, 1, 1, 8'hFE, 0, 8'hFE, 0, 0));
        vecs.push_back(mk(0, 1, 2, 8'h00, 0, 8'hFF, 0, 0));
        vecs.push_back(mk(0, 1, 2, 8'h00, 0, 8'h00, 1, 1));  // INC wrap
        vecs.push_back(mk(0, 1, 3, 8'h00, 0, 8'hFF, 1, 0));  // DEC borrow
        vecs.push_back(mk(0, 1, 1, 8'h81, 0, 8'h81, 0, 0));
        vecs.push_back(mk(0, 1, 4, 8'h00, 1, 8'h03, 1, 0));  // SHL sin=1
        vecs.push_back(mk(0, 1, 1, 8'h81, 0, 8'h81, 0, 0));
        vecs.push_back(mk(0, 1, 5, 8'h00, 0, 8'h40, 1, 0));  // SHR sin=0
        vecs.push_back(mk(0, 1, 1, 8'h01, 0, 8'h01, 0, 0));
        vecs.push_back(mk(0, 1, 7, 8'h00, 0, 8'h80, 1, 0));  // ROR, sin ignored
        vecs.push_back(mk(0, 1, 6, 8'h00, 0, 8'h01, 1, 0));  // ROL, sin ignored
        vecs.push_back(mk(0, 1, 3, 8'h00, 0, 8'h00, 0, 1));  // DEC no borrow
        vecs.push_back(mk(0, 1, 3, 8'h00, 0, 8'hFF, 1, 0));
        vecs.push_back(mk(0, 1, 2, 8'h00, 1, 8'h00, 1, 1));
        vecs.push_back(mk(0, 1, 2, 8'h00, 1, 8'h01, 0, 0));  // INC no carry
        vecs.push_back(mk(0, 1, 1, 8'h79, 0, 8'h79, 0, 0));
        vecs.push_back(mk(0, 1, 5, 8'h00, 0, 8'h3C, 1, 0));  // leaves cout=1
        for (int m = 0; m < 8; m++)
            vecs.push_back(mk(0, 0, 3'(m), 8'hFF, 1, 8'h3C, 1, 0));  // en=0 holds
        vecs.push_back(mk(0, 1, 0, 8'hFF, 1, 8'h3C, 1, 0));  // HOLD with en=1
        vecs.push_back(mk(0, 1, 6, 8'h00, 1, 8'h78, 0, 0));  // ROL 3C
        vecs.push_back(mk(0, 1, 4, 8'h00, 0, 8'hF0, 0, 0));  // SHL 78
        vecs.push_back(mk(0, 1, 4, 8'h00, 0, 8'hE0, 1, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive8(vecs[i].rst, vecs[i].en, vecs[i].mode, vecs[i].data, vecs[i].sin);
            check8($sformatf("vec%0d %s", i, mode_name(mode_e'(vecs[i].mode))),
                   vecs[i].exp_out, vecs[i].exp_cout, vecs[i].exp_zero);
        end

        // Reset asserted mid-count, then counting resumes from the reset value.
        drive8(0, 1, 1, 8'h10, 0); check8("rp load", 8'h10, 0, 0);
        drive8(0, 1, 2, 8'h00, 0); check8("rp inc1", 8'h11, 0, 0);
        drive8(0, 1, 2, 8'h00, 0); check8("rp inc2", 8'h12, 0, 0);
        drive8(1, 1, 2, 8'h00, 0); check8("rp rst",  8'h00, 0, 1);
        drive8(0, 1, 2, 8'h00, 0); check8("rp res1", 8'h01, 0, 0);
        drive8(0, 1, 2, 8'h00, 0); check8("rp res2", 8'h02, 0, 0);

        // Reset must clear a set carry as well.
        drive8(0, 1, 1, 8'hFF, 0); check8("rc load", 8'hFF, 0, 0);
        drive8(0, 1, 2, 8'h00, 0); check8("rc inc",  8'h00, 1, 1);
        drive8(1, 0, 2, 8'h00, 0); check8("rc rst",  8'h00, 0, 1);

        // 16-bit instance with non-zero reset value.
        drive16(1, 0, 0, 16'h0000, 0); check16("w16 rst",  16'h00FF, 0, 0);
        drive16(0, 1, 1, 16'hFFFF, 0); check16("w16 load", 16'hFFFF, 0, 0);
        drive16(0, 1, 2, 16'h0000, 0); check16("w16 inc",  16'h0000, 1, 1);
        drive16(0, 1, 1, 16'h8000, 0); check16("w16 ld8k", 16'h8000, 0, 0);
        drive16(0, 1, 4, 16'h0000, 0); check16("w16 shl",  16'h0000, 1, 1);
        drive16(0, 1, 3, 16'h0000, 0); check16("w16 dec",  16'hFFFF, 1, 0);
        drive16(0, 1, 7, 16'h0000, 0); check16("w16 ror",  16'hFFFF, 1, 0);
        drive16(1, 1, 2, 16'h0000, 0); check16("w16 rst2", 16'h00FF, 0, 0);
        drive16(0, 1, 2, 16'h0000, 0); check16("w16 res",  16'h0100, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
